mem_initiator: RTL

Command-driven master for the 16x32 register-file memory. It accepts read/write commands on a valid/ready interface and drives the memory's EN/Addr/Data_In pins. Writes use EN=1; reads use EN=0, and the memory's registered Data_Out/Valid_Out is captured one cycle later. Read data returns on a valid/ready response channel. The block sits between testbench/sequencer logic and the memory.

---
 rtl/mem_initiator.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_initiator.sv
// mem_initiator: command-driven master for the 16x32 register-file memory.
// Latency: write accepted at edge k commits at edge k+1. Read accepted at edge k gives rsp_valid in cycle k+3.
// Backpressure: cmd_ready is high only in IDLE. A response is held stable until rsp_ready, and no command is taken meanwhile.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata   command channel (valid/ready)
//   rsp_valid/ready/rdata/err          read response channel (valid/ready)
//   mem_EN/Addr/Data_In                registered memory drive (EN=1 write, EN=0 read)
//   mem_Data_Out/Valid_Out             registered memory read return
//   wr_cnt, rd_cnt                     completed-transaction counters, wrap
//
// Build option: define MEM_INIT_WR_VERIFY_EN to make every write do a
// read-back at the same address and report mismatch/timeout on rsp_err.
module mem_initiator #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_EN,
    output logic [ADDR_W-1:0] mem_Addr,
    output logic [DATA_W-1:0] mem_Data_In,
    input  logic [DATA_W-1:0] mem_Data_Out,
    input  logic              mem_Valid_Out,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`ifdef MEM_INIT_WR_VERIFY_EN
    // Marks the current read as the read-back of a write.
    logic               is_wr_q, is_wr_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        tmo_d       = tmo_q;
`ifdef MEM_INIT_WR_VERIFY_EN
        is_wr_d     = is_wr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mem_addr_d  = cmd_addr;
                    mem_wdata_d = cmd_wdata;
                    mem_en_d    = cmd_write;
                    state_d     = cmd_write ? S_WR : S_RD;
`ifdef MEM_INIT_WR_VERIFY_EN
                    is_wr_d     = cmd_write;
`endif
                end
            end
            S_WR: begin
                // The memory commits the write on this edge.
                mem_en_d = 1'b0;
`ifdef MEM_INIT_WR_VERIFY_EN
                state_d  = S_RD;
`else
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
                state_d  = S_IDLE;
`endif
            end
            S_RD: begin
                // The memory registers Data_Out on this edge; sample it in CAP.
                tmo_d   = '0;
                state_d = S_CAP;
            end
            S_CAP: begin
                if (mem_Valid_Out) begin
                    rsp_rdata_d = mem_Data_Out;
`ifdef MEM_INIT_WR_VERIFY_EN
                    rsp_err_d   = is_wr_q && (mem_Data_Out != mem_wdata_q);
`else
                    rsp_err_d   = 1'b0;
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    // This is the TIMEOUT_CYC-th CAP cycle without valid data.
                    if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef MEM_INIT_WR_VERIFY_EN
                    if (is_wr_q) begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
`else
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            tmo_q       <= '0;
`ifdef MEM_INIT_WR_VERIFY_EN
            is_wr_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            tmo_q       <= tmo_d;
`ifdef MEM_INIT_WR_VERIFY_EN
            is_wr_q     <= is_wr_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign mem_EN      = mem_en_q;
    assign mem_Addr    = mem_addr_q;
    assign mem_Data_In = mem_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;

endmodule
